// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversamples SCK/ENA/MOSI in the i_CLK domain and
// deserialises MSB-first words onto a one-deep valid/ready output buffer.
module spi_slave_rx #(
  parameter int unsigned BIT_WIDTH   = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  input  logic                 i_SPI_CLK,
  input  logic                 i_SPI_ENA,
  input  logic                 i_SPI_DAT,
  output logic [BIT_WIDTH-1:0] o_DATA,
  output logic                 o_VALID,
  input  logic                 i_READY,
  output logic                 o_OVERRUN,
  output logic                 o_ABORT,
  output logic                 o_BUSY
);

  localparam int unsigned CNT_W = $clog2(BIT_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, ena_sync_q, dat_sync_q;
  logic                   sck_d_q, ena_d_q;
  logic                   sck_s, ena_s, dat_s;
  logic                   rise, ena_fall, ena_rise;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BIT_WIDTH-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   abort_q, abort_d;
  logic                   busy_q, busy_d;

  // Synchronisers plus one delay flop for edge detection; idle levels on reset.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      sck_sync_q <= '0;
      ena_sync_q <= '1;
      dat_sync_q <= '0;
      sck_d_q    <= 1'b0;
      ena_d_q    <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], i_SPI_CLK};
      ena_sync_q <= {ena_sync_q[SYNC_STAGES-2:0], i_SPI_ENA};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], i_SPI_DAT};
      sck_d_q    <= sck_s;
      ena_d_q    <= ena_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ena_s    = ena_sync_q[SYNC_STAGES-1];
  assign dat_s    = dat_sync_q[SYNC_STAGES-1];
  assign rise     = sck_s & ~sck_d_q;
  assign ena_fall = ~ena_s & ena_d_q;
  assign ena_rise = ena_s & ~ena_d_q;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q   <= WAIT_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      abort_q   <= abort_d;
      busy_q    <= busy_d;
    end
  end

  // Next state: ENA rising has priority over a coincident SCK rise.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q & ~i_READY;
    overrun_d = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        cnt_d = '0;
        if (ena_s) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (ena_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (ena_rise) begin
          abort_d = (cnt_q != '0);
          cnt_d   = '0;
          state_d = IDLE;
        end else if (rise) begin
          shreg_d = {shreg_q[BIT_WIDTH-2:0], dat_s};
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            if (!valid_q || i_READY) begin
              data_d  = {shreg_q[BIT_WIDTH-2:0], dat_s};
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  assign o_DATA    = data_q;
  assign o_VALID   = valid_q;
  assign o_OVERRUN = overrun_q;
  assign o_ABORT   = abort_q;
  assign o_BUSY    = busy_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomised bench for spi_slave_rx: a word-level model fills a scoreboard
// queue and a negedge monitor pops and compares each accepted output word.
`timescale 1ns/1ps
module tb_spi_slave_rx;

  localparam int unsigned BW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sck, ena, dat;
  logic [BW-1:0] o_data;
  logic          o_valid, i_ready, o_overrun, o_abort, o_busy;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] fw[8];
  int  abort_exp = 0, abort_seen = 0, ovr_exp = 0, ovr_seen = 0;
  bit  ignore_pulses = 1'b0;
  bit  rand_ready = 1'b0;
  bit  ready_manual = 1'b1;

  spi_slave_rx #(.BIT_WIDTH(BW), .SYNC_STAGES(2)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_SPI_CLK(sck), .i_SPI_ENA(ena),
    .i_SPI_DAT(dat), .o_DATA(o_data), .o_VALID(o_valid), .i_READY(i_ready),
    .o_OVERRUN(o_overrun), .o_ABORT(o_abort), .o_BUSY(o_busy)
  );

  initial forever #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Consumer: manual level, or random stalls no longer than 50 cycles.
  initial begin
    int stall_left = 0;
    i_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (!rand_ready) i_ready = ready_manual;
      else if (stall_left > 0) begin
        stall_left--;
        i_ready = 1'b0;
      end else begin
        i_ready = 1'b1;
        if ($urandom_range(0, 15) == 0) stall_left = $urandom_range(1, 50);
      end
    end
  end

  // Monitor: scoreboard pops, hold-while-stalled and single-cycle pulse checks.
  initial begin
    logic          prev_stall = 1'b0, prev_abort = 1'b0, prev_ovr = 1'b0;
    logic [BW-1:0] prev_data = '0;
    logic [BW-1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0; prev_abort = 1'b0; prev_ovr = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(o_valid), 32'd1);
          chk("hold_data", 32'(o_data), 32'(prev_data));
        end
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %h, required no word", o_data);
          end else begin
            exp = exp_q.pop_front();
            chk("word", 32'(o_data), 32'(exp));
          end
        end
        if (o_abort) begin
          if (!ignore_pulses) abort_seen++;
          if (prev_abort) chk("abort_width", 32'd2, 32'd1);
        end
        if (o_overrun) begin
          if (!ignore_pulses) ovr_seen++;
          if (prev_ovr) chk("overrun_width", 32'd2, 32'd1);
        end
        prev_stall = o_valid && !i_ready;
        prev_data  = o_data;
        prev_abort = o_abort;
        prev_ovr   = o_overrun;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, 32'(o_data), 32'd0);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_overrun"}, 32'(o_overrun), 32'd0);
    chk({tag, "_abort"}, 32'(o_abort), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  // Frame of nbits from fw[] MSB first; model: each full word is delivered,
  // a trailing partial word aborts, and a stalled consumer keeps only word 0.
  task automatic send_frame(input int nbits, input bit stalled, input bit chk_busy,
                            input bit lat_chk);
    int full = nbits / BW;
    for (int k = 0; k < full; k++) begin
      if (!stalled || k == 0) exp_q.push_back(fw[k]);
      else ovr_exp++;
    end
    if (nbits % BW != 0) abort_exp++;
    @(negedge clk); #3;
    ena = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      dat = fw[i / BW][BW - 1 - (i % BW)];
      if (chk_busy) chk("busy_in_frame", 32'(o_busy), 32'd1);
      #100 sck = 1'b1;
      if (lat_chk && i == nbits - 1) begin
        repeat (2) @(posedge clk);
        #1 chk("latency_early", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1 chk("latency_valid", 32'(o_valid), 32'd1);
        #52;
      end else begin
        #100;
      end
      sck = 1'b0;
    end
    #100 ena = 1'b1;
    #300;
  endtask

  task automatic drain_and_count(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d words pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    chk({tag, "_aborts"}, 32'(abort_seen), 32'(abort_exp));
    chk({tag, "_overruns"}, 32'(ovr_seen), 32'(ovr_exp));
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; sck = 1'b0; dat = 1'b0;
    #25 check_reset_outputs("reset");
    #18 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Single word with latency check.
    fw[0] = 24'hA5C3F0;
    send_frame(24, 1'b0, 1'b0, 1'b1);
    drain_and_count("one_word");

    // Two back-to-back words in one frame, BUSY throughout.
    fw[0] = 24'h123456; fw[1] = 24'hFEDCBA;
    send_frame(48, 1'b0, 1'b1, 1'b0);
    chk("busy_after_frame", 32'(o_busy), 32'd0);
    drain_and_count("two_words");

    // Abort after 10 bits, then a clean word.
    fw[0] = 24'h5A5A5A;
    send_frame(10, 1'b0, 1'b0, 1'b0);
    drain_and_count("abort");
    fw[0] = 24'h00FF00;
    send_frame(24, 1'b0, 1'b0, 1'b0);
    drain_and_count("after_abort");

    // Stalled consumer: second word overruns, first is held.
    ready_manual = 1'b0;
    repeat (2) @(posedge clk);
    fw[0] = 24'h111111; fw[1] = 24'h222222;
    send_frame(48, 1'b1, 1'b0, 1'b0);
    chk("stall_valid", 32'(o_valid), 32'd1);
    chk("stall_data", 32'(o_data), 32'h111111);
    chk("stall_overruns", 32'(ovr_seen), 32'(ovr_exp));
    ready_manual = 1'b1;
    @(posedge clk); #5;
    @(posedge clk);
    #1 chk("valid_drop", 32'(o_valid), 32'd0);
    drain_and_count("overrun");

    // Reset mid-frame; remaining bits must not produce a word.
    @(negedge clk); #3;
    ena = 1'b0;
    #100;
    for (int i = 0; i < 8; i++) begin
      dat = 1'($urandom);
      #100 sck = 1'b1;
      #100 sck = 1'b0;
    end
    ignore_pulses = 1'b1;
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    #19 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dat = 1'($urandom);
      #100 sck = 1'b1;
      #100 sck = 1'b0;
    end
    #100 ena = 1'b1;
    #300;
    ignore_pulses = 1'b0;
    drain_and_count("midreset");
    fw[0] = 24'hC0FFEE;
    send_frame(24, 1'b0, 1'b0, 1'b0);
    drain_and_count("after_reset");

    // SCK activity with ENA high is ignored.
    @(negedge clk); #3;
    for (int i = 0; i < 30; i++) begin
      dat = 1'($urandom);
      #100 sck = ~sck;
      chk("idle_busy", 32'(o_busy), 32'd0);
    end
    sck = 1'b0;
    #300;
    drain_and_count("sck_idle");

    // Random frames with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      int nb;
      for (int k = 0; k < 8; k++) fw[k] = 24'($urandom);
      nb = ($urandom_range(0, 1) == 0) ? BW * $urandom_range(1, 3) : $urandom_range(1, 72);
      send_frame(nb, 1'b0, 1'b0, 1'b0);
      drain_and_count("random");
    end
    rand_ready = 1'b0;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
